// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types, default polynomial and masked parity helper
package lfsr_pkg;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } lfsr_fsm_e;

   localparam int LFSR_LEN_DEF = 16;
   localparam logic [0:LFSR_LEN_DEF-1] LFSR_TAPS_DEF = 16'b0110100000000001;

   // Widest LFSR the parity helper accepts; callers zero-extend into it.
   localparam int LFSR_MAX_LEN = 64;

   function automatic logic lfsr_parity(input logic [LFSR_MAX_LEN-1:0] state,
                                        input logic [LFSR_MAX_LEN-1:0] taps);
      return ^(state & taps);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // Clear beats a same-cycle increment.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with lock FSM and BER counters
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int                LENGTH   = LFSR_LEN_DEF,
   parameter logic [0:LENGTH-1] TAPS     = LFSR_TAPS_DEF,
   parameter int                LOCK_CNT = 32,
   parameter int                LOSS_CNT = 8,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              clear_cnt,
   output logic              locked,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  bit_count,
   output logic [0:LENGTH-1] lfsr_state
);

   localparam int FILL_W  = $clog2(LENGTH + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int CONS_W  = $clog2(LOSS_CNT + 1);

   lfsr_fsm_e          state_q, state_d;
   logic [0:LENGTH-1]  lfsr_q, lfsr_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [CONS_W-1:0]  consec_q, consec_d;
   logic               pulse_q, pulse_d;

   logic expected, mismatch, state_zero, shift_bit;
   logic err_inc, bit_inc;

   assign expected   = lfsr_parity(LFSR_MAX_LEN'(lfsr_q), LFSR_MAX_LEN'(TAPS));
   assign mismatch   = bit_in ^ expected;
   assign state_zero = (lfsr_q == '0);

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      fill_d    = fill_q;
      match_d   = match_q;
      consec_d  = consec_q;
      pulse_d   = 1'b0;
      err_inc   = 1'b0;
      bit_inc   = 1'b0;
      shift_bit = bit_in;

      if (bit_valid) begin
         unique case (state_q)
            SEED: begin
               fill_d = fill_q + FILL_W'(1);
               if (fill_q == FILL_W'(LENGTH - 1)) begin
                  state_d = SYNC;
                  match_d = '0;
               end
            end
            SYNC: begin
               // A zero state predicts zero forever, so it must never build lock.
               if (!mismatch && !state_zero) begin
                  match_d = match_q + MATCH_W'(1);
                  if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                     state_d  = LOCKED;
                     consec_d = '0;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               // Free-run on the prediction so a channel error is not fed back.
               shift_bit = expected;
               bit_inc   = 1'b1;
               if (mismatch) begin
                  pulse_d = 1'b1;
                  err_inc = 1'b1;
                  if (consec_q == CONS_W'(LOSS_CNT - 1)) begin
                     state_d  = SEED;
                     fill_d   = '0;
                     consec_d = '0;
                  end else begin
                     consec_d = consec_q + CONS_W'(1);
                  end
               end else begin
                  consec_d = '0;
               end
            end
            default: begin
               state_d = SEED;
               fill_d  = '0;
            end
         endcase
         lfsr_d = {shift_bit, lfsr_q[0:LENGTH-2]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= SEED;
         lfsr_q   <= '0;
         fill_q   <= '0;
         match_q  <= '0;
         consec_q <= '0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         fill_q   <= fill_d;
         match_q  <= match_d;
         consec_q <= consec_d;
         pulse_q  <= pulse_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) err_cnt_u (
      .clk_i   (clk),
      .rst_ni  (rst),
      .inc_i   (err_inc),
      .clr_i   (clear_cnt),
      .count_o (err_count)
   );

   sat_counter #(.WIDTH(CNT_W)) bit_cnt_u (
      .clk_i   (clk),
      .rst_ni  (rst),
      .inc_i   (bit_inc),
      .clr_i   (clear_cnt),
      .count_o (bit_count)
   );

   assign locked     = (state_q == LOCKED);
   assign err_pulse  = pulse_q;
   assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker against a queue-based reference model
module tb_lfsr_checker;

   localparam int L = 16;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic clear_cnt = 1'b0;

   logic          locked, err_pulse, s_locked, s_err_pulse;
   logic [15:0]   err_count, bit_count;
   logic [SW-1:0] s_err_count, s_bit_count;
   logic [0:L-1]  lfsr_state, s_lfsr_state;

   always #5 clk = ~clk;

   lfsr_checker #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .bit_count(bit_count), .lfsr_state(lfsr_state)
   );

   lfsr_checker #(.CNT_W(SW)) dut_s (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear_cnt(clear_cnt),
      .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
      .bit_count(s_bit_count), .lfsr_state(s_lfsr_state)
   );

   typedef struct {
      logic         lk;
      logic         pl;
      int           err;
      int           bits;
      int           serr;
      int           sbits;
      logic [0:L-1] st;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int pulses_seen = 0;

   logic [0:L-1] taps_v = 16'b0110100000000001;
   logic [0:L-1] g;

   // Reference model: mode 0 fill, 1 hunting, 2 locked; window newest-first.
   int m_mode, m_fill, m_match, m_consec, m_err, m_bits, m_serr, m_sbits;
   bit m_pulse;
   bit m_win[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit rn, input bit v, input bit b, input bit clr);
      bit pred, nz;
      int smax;
      smax = (1 << SW) - 1;
      if (!rn) begin
         m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0;
         m_err = 0; m_bits = 0; m_serr = 0; m_sbits = 0; m_pulse = 0;
         m_win.delete();
         repeat (L) m_win.push_back(1'b0);
         return;
      end
      m_pulse = 0;
      if (v) begin
         pred = 0; nz = 0;
         for (int i = 0; i < L; i++) begin
            pred ^= taps_v[i] & m_win[i];
            nz |= m_win[i];
         end
         if (m_mode == 0) begin
            m_fill++;
            m_win.push_front(b);
            if (m_fill == L) begin m_mode = 1; m_match = 0; end
         end else if (m_mode == 1) begin
            m_match = (b == pred && nz) ? m_match + 1 : 0;
            m_win.push_front(b);
            if (m_match == 32) begin m_mode = 2; m_consec = 0; end
         end else begin
            m_win.push_front(pred);
            if (m_bits < 65535) m_bits++;
            if (m_sbits < smax) m_sbits++;
            if (b != pred) begin
               m_pulse = 1;
               if (m_err < 65535) m_err++;
               if (m_serr < smax) m_serr++;
               m_consec++;
               if (m_consec == 8) begin m_mode = 0; m_fill = 0; m_consec = 0; end
            end else begin
               m_consec = 0;
            end
         end
         void'(m_win.pop_back());
      end
      if (clr) begin m_err = 0; m_bits = 0; m_serr = 0; m_sbits = 0; end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.lk = (m_mode == 2); e.pl = m_pulse;
      e.err = m_err; e.bits = m_bits; e.serr = m_serr; e.sbits = m_sbits;
      for (int i = 0; i < L; i++) e.st[i] = m_win[i];
      return e;
   endfunction

   task automatic step(input bit rn, input bit v, input bit b, input bit clr);
      @(negedge clk);
      rst = rn; bit_valid = v; bit_in = b; clear_cnt = clr;
      model(rn, v, b, clr);
      sb.push_back(snapshot());
   endtask

   task automatic gen(output bit nb);
      nb = ^(g & taps_v);
      g = {nb, g[0:L-2]};
   endtask

   task automatic clean(input int n, input int spacing);
      bit b;
      for (int i = 0; i < n; i++) begin
         gen(b);
         step(1, 1, b, 0);
         for (int k = 1; k < spacing; k++) step(1, 0, 1'($urandom), 0);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      g = 16'hACE1;
      step(0, 0, 0, 0);
      step(0, 1, 1, 1);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_locked", locked, e.lk);
         chk("sb_err_pulse", err_pulse, e.pl);
         chk("sb_err_count", err_count, e.err);
         chk("sb_bit_count", bit_count, e.bits);
         chk("sb_lfsr_state", lfsr_state, e.st);
         chk("sb_small_err_count", s_err_count, e.serr);
         chk("sb_small_bit_count", s_bit_count, e.sbits);
         chk("sb_small_locked", s_locked, e.lk);
         if (err_pulse === 1'b1) pulses_seen++;
      end
   end

   initial begin
      bit b;
      int p0, w;

      do_reset();
      settle();
      chk("reset_locked", locked, 0);
      chk("reset_state", lfsr_state, 0);
      chk("reset_counts", {err_count, bit_count}, 0);

      clean(47, 1);
      settle();
      chk("clean_not_yet_locked", locked, 0);
      clean(1, 1);
      settle();
      chk("clean_locked_after_48", locked, 1);
      clean(952, 1);
      settle();
      chk("clean_err_count", err_count, 0);
      chk("clean_bit_count", bit_count, 952);

      clean(99, 1);
      p0 = pulses_seen;
      gen(b);
      step(1, 1, ~b, 0);
      settle();
      chk("flip_pulse", err_pulse, 1);
      clean(50, 1);
      settle();
      chk("flip_err_count", err_count, 1);
      chk("flip_still_locked", locked, 1);
      chk("flip_single_pulse", pulses_seen - p0, 1);
      chk("flip_bit_count", bit_count, 1102);

      do_reset();
      clean(47, 3);
      settle();
      chk("sparse_not_locked", locked, 0);
      clean(1, 3);
      settle();
      chk("sparse_locked", locked, 1);
      clean(100, 3);
      settle();
      chk("sparse_bit_count", bit_count, 100);
      chk("sparse_err_count", err_count, 0);

      do_reset();
      for (int i = 0; i < 500; i++) step(1, 1, 0, 0);
      settle();
      chk("zero_not_locked", locked, 0);
      chk("zero_state", lfsr_state, 0);

      do_reset();
      clean(60, 1);
      for (int i = 0; i < 7; i++) begin gen(b); step(1, 1, ~b, 0); end
      settle();
      chk("loss_held_after_7", locked, 1);
      gen(b);
      step(1, 1, ~b, 0);
      settle();
      chk("loss_dropped_after_8", locked, 0);
      chk("loss_err_count", err_count, 8);
      clean(47, 1);
      settle();
      chk("relock_not_yet", locked, 0);
      clean(1, 1);
      settle();
      chk("relock", locked, 1);
      chk("relock_err_count", err_count, 8);

      clean(20, 1);
      gen(b);
      step(1, 1, ~b, 1);
      settle();
      chk("clr_err_count", err_count, 0);
      chk("clr_bit_count", bit_count, 0);
      chk("clr_locked", locked, 1);
      clean(5, 1);
      settle();
      chk("clr_then_bits", bit_count, 5);

      for (int i = 0; i < 400; i++) begin
         bit v, flip, clr;
         v = ($urandom_range(0, 3) != 0);
         flip = ($urandom_range(0, 15) == 0);
         clr = ($urandom_range(0, 99) == 0);
         if (v) begin
            gen(b);
            step(1, 1, b ^ flip, clr);
         end else begin
            step(1, 0, 1'($urandom), clr);
         end
      end

      do_reset();
      clean(50, 1);
      settle();
      chk("pre_reset_locked", locked, 1);
      gen(b);
      step(0, 1, ~b, 0);
      settle();
      chk("midlock_reset_locked", locked, 0);
      chk("midlock_reset_counts", {err_count, bit_count}, 0);
      chk("midlock_reset_state", lfsr_state, 0);
      chk("midlock_reset_pulse", err_pulse, 0);

      w = 0;
      while (sb.size() > 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
